// File: rtl/sfifo_prog.sv
// rtl/sfifo_prog.sv - synchronous FIFO with programmable almost-full/empty flags,
// sticky error flags and optional first-word-fall-through output.
module sfifo_prog #(
   parameter int DEPTH     = 16,
   parameter int WIDTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_wr_en,
   input  logic [WIDTH-1:0]         i_data_in,
   input  logic                     i_rd_en,
   input  logic                     i_flush,
   input  logic                     i_clr_err,
   output logic [WIDTH-1:0]         o_data_out,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow,
   output logic                     o_underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
   localparam logic [AW:0] AF_L    = (AW+1)'(AF_THRESH);
   localparam logic [AW:0] AE_L    = (AW+1)'(AE_THRESH);

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("sfifo_prog: DEPTH must be a power of two and at least 2");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("sfifo_prog: AF_THRESH must be in 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("sfifo_prog: AE_THRESH must be in 0..DEPTH-1");
   end
   if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("sfifo_prog: FWFT must be 0 or 1");
   end

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr, count;
   logic [AW-1:0]    wr_addr, rd_addr;
   logic             empty, full, rd_acc, wr_acc;
   logic [WIDTH-1:0] dout_q;

   // Extra pointer bit distinguishes full from empty, so occupancy is a plain difference.
   assign count   = wr_ptr - rd_ptr;
   assign wr_addr = wr_ptr[AW-1:0];
   assign rd_addr = rd_ptr[AW-1:0];
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_L);
   assign rd_acc  = i_rd_en & ~empty;
   assign wr_acc  = i_wr_en & (~full | rd_acc);

   assign o_count        = count;
   assign o_empty        = empty;
   assign o_full         = full;
   assign o_almost_full  = (count >= AF_L);
   assign o_almost_empty = (count <= AE_L);
   assign o_data_out     = dout_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage deliberately has no reset; pointers alone define what is valid.
   always_ff @(posedge i_clk) begin
      if (wr_acc && !i_flush) mem[wr_addr] <= i_data_in;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_overflow  <= (i_wr_en & ~wr_acc) | (o_overflow & ~i_clr_err);
         o_underflow <= (i_rd_en & ~rd_acc) | (o_underflow & ~i_clr_err);
      end
   end

   if (FWFT == 0) begin : g_std
      logic valid_q;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
         end else if (i_flush) begin
            valid_q <= 1'b0;
         end else begin
            valid_q <= rd_acc;
            if (rd_acc) dout_q <= mem[rd_addr];
         end
      end

      assign o_valid = valid_q;
   end else begin : g_fwft
      logic [AW:0] nxt_rd_ptr, nxt_count;

      assign nxt_rd_ptr = rd_ptr + {{AW{1'b0}}, rd_acc};
      assign nxt_count  = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

      // Output register tracks the post-edge head; bypass when the new word becomes the head.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            dout_q <= '0;
         end else if (!i_flush && nxt_count != '0) begin
            if (wr_acc && wr_addr == nxt_rd_ptr[AW-1:0]) dout_q <= i_data_in;
            else                                         dout_q <= mem[nxt_rd_ptr[AW-1:0]];
         end
      end

      assign o_valid = ~empty;
   end

endmodule

// File: doc/sfifo_prog.md
SFIFO_PROG -- requirements
Module: sfifo_prog

Interface
REQ-001 Parameter: DEPTH, default 16, number of entries; SHALL be a power of two and at least 2.
REQ-002 Parameter: WIDTH, default 8, data bits per entry.
REQ-003 Parameter: AF_THRESH, default DEPTH-2, almost-full level; legal range 1..DEPTH.
REQ-004 Parameter: AE_THRESH, default 2, almost-empty level; legal range 0..DEPTH-1.
REQ-005 Parameter: FWFT, default 0; 0 = standard read, 1 = first-word-fall-through.
REQ-006 Port: i_clk  in  1  clock; all state SHALL change on its rising edge only.
REQ-007 Port: i_rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port: i_wr_en  in  1  write request.
REQ-009 Port: i_data_in  in  WIDTH  write data.
REQ-010 Port: i_rd_en  in  1  read request.
REQ-011 Port: i_flush  in  1  synchronous clear of all contents.
REQ-012 Port: i_clr_err  in  1  synchronous clear of the sticky error flags.
REQ-013 Port: o_data_out  out  WIDTH  read data.
REQ-014 Port: o_valid  out  1  o_data_out holds a popped word (FWFT=0) or the head word (FWFT=1).
REQ-015 Port: o_full, o_empty, o_almost_full, o_almost_empty  out  1 each  status flags.
REQ-016 Port: o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-017 Port: o_overflow, o_underflow  out  1 each  sticky error flags.

Function
REQ-018 Pointers SHALL be $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; the memory SHALL be addressed by the low $clog2(DEPTH) bits.
REQ-019 Flags: o_empty = (count==0); o_full = (count==DEPTH); o_almost_full = (count>=AF_THRESH); o_almost_empty = (count<=AE_THRESH); all decoded from registered state only.
REQ-020 Write acceptance: accepted when i_wr_en=1 and either o_full=0, or o_full=1 with a read accepted in the same cycle.
REQ-021 Read acceptance: accepted when i_rd_en=1 and o_empty=0; a read while empty is rejected, even when a write occurs in the same cycle (no pass-through).
REQ-022 Count: o_count SHALL increment by 1 (write only), decrement by 1 (read only), and be unchanged (both, or neither).
REQ-023 Overflow: a write request that is rejected SHALL set o_overflow on the next edge, with no change to memory or pointers.
REQ-024 Underflow: a rejected read request SHALL set o_underflow on the next edge, with no change to pointers.
REQ-025 Error flags: both flags SHALL stay set until i_clr_err=1; if a set and a clear coincide, set SHALL win.
REQ-026 FWFT=0: an accepted read SHALL register mem[rd_addr] into o_data_out, and o_valid=1 in the next cycle only.
REQ-027 FWFT=0 hold: o_data_out SHALL keep its last value when no read is accepted.
REQ-028 FWFT=1: o_data_out SHALL equal the head word whenever o_empty=0, and o_valid SHALL equal ~o_empty.
REQ-029 FWFT=1 latency: a word written into an empty FIFO at edge N SHALL be visible at o_data_out after edge N.
REQ-030 FWFT=1 pop: an accepted read SHALL present the next word, or deassert o_valid, after the edge.
REQ-031 Flush: i_flush=1 SHALL zero both pointers and o_count, and clear o_valid, at the edge.
REQ-032 Flush priority: i_flush SHALL override any write or read in the same cycle; it SHALL NOT clear the error flags or o_data_out.
REQ-033 Elaboration: an illegal parameter value SHALL cause an elaboration-time error.

Reset
REQ-034 With i_rst_n=0, asynchronously and independent of i_clk: pointers=0, o_count=0, o_empty=1, o_almost_empty=1, o_full=0, o_almost_full=0 (AF_THRESH>0), o_valid=0, o_overflow=0, o_underflow=0, o_data_out=0.
REQ-035 Reset SHALL NOT clear the memory array; after deassertion the FIFO SHALL behave as empty.
REQ-036 Reset asserted mid-transfer SHALL discard all stored words, and no stale word SHALL appear on o_data_out.

Verification (DEPTH=8, WIDTH=8, AF_THRESH=6, AE_THRESH=2)
REQ-037 Fill: write 0x01..0x08, FWFT=0 -> o_almost_empty drops at count 3, o_almost_full rises at 6, o_full=1 at count 8; a 9th write sets o_overflow and leaves o_count=8.
REQ-038 Drain: drain the 8 words, FWFT=0 -> o_data_out=0x01..0x08 each one cycle after its read with o_valid=1; a 9th read sets o_underflow; i_clr_err clears both error flags.
REQ-039 Full boundary: at full, write 0xAA together with a read -> both accepted, o_count stays 8, and 0xAA is read out last after 7 further reads (pointer wrap checked).
REQ-040 Empty boundary: at empty, FWFT=1, write 0x5A together with a read -> read rejected and o_underflow=1; next cycle o_data_out=0x5A, o_valid=1, o_count=1.
REQ-041 Flush vs reset: with 5 words stored, assert i_flush together with a write -> o_count=0, o_empty=1, write discarded; then repeat the fill and pulse i_rst_n low between clock edges -> all flags at reset values immediately.
REQ-042 Random: random i_wr_en/i_rd_en at 50% for 10000 cycles, both FWFT values -> data order and o_count match a reference queue model, and no flag mismatch.
